ip_checksum_insert: RTL and testbench
=====================================

# ip_checksum_insert

AXI4-Stream stage in the router output-port-lookup pipeline that writes the IPv4 header checksum into forwarded frames. It holds the first 256-bit beat of each packet until the second beat arrives, because the last header word (destination-IP low 16 bits) is carried in the second beat. It then computes the RFC 791 ones-complement checksum, overwrites the checksum field in the held beat, and emits the packet unchanged otherwise. Non-IPv4 frames, frames with options, and single-beat frames pass through untouched.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master TDATA width (fixed at 256)
- C_S_AXIS_DATA_WIDTH, 256, slave TDATA width (fixed at 256)
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width

Ports:
- AXI_ACLK  in  1  single clock
- AXI_RESETN  in  1  asynchronous, active-low reset
- S_AXIS_TDATA  in  256  input data; packet byte 0 is at [255:248]
- S_AXIS_TSTRB  in  32  input byte strobes
- S_AXIS_TUSER  in  128  input sideband
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- S_AXIS_TLAST  in  1  input end of packet
- M_AXIS_TDATA  out  256  output data
- M_AXIS_TSTRB  out  32  output strobes
- M_AXIS_TUSER  out  128  output sideband
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- M_AXIS_TLAST  out  1  output end of packet
- csum_enable  in  1  1 = rewrite eligible headers; 0 = pure pass-through timing, data unmodified
- rewrite_count  out  32  number of headers rewritten; wraps at 2^32

## Operation
- Hold register H stores {TLAST, TUSER, TSTRB, TDATA} plus an eligibility flag E.
- Field positions in beat 0:
  - ethertype at [159:144]
  - version/IHL at [143:136]
  - IP header word i (i = 0..8) at [143-16i:128-16i]
  - checksum field (word 5) at [63:48]
- Word 9 (destination-IP low) comes from beat 1 at [255:240].
- E = csum_enable && ethertype==16'h0800 && version/IHL==8'h45. E is evaluated at beat-0 capture.
- Checksum computation:
  - 20-bit sum of words 0–4 and 6–9; word 5 is treated as 0.
  - Fold twice: s = s[15:0] + s[19:16].
  - Invert: csum = ~s[15:0].
  - Result is written to H[63:48] only when E = 1.
- State machine:
  - WAIT_HDR
    - S_TREADY=1, M_TVALID=0.
    - On S handshake: capture into H.
    - If TLAST: go to SEND_HDR with no rewrite, E forced 0.
    - Else: go to WAIT_SECOND.
  - WAIT_SECOND
    - S_TREADY=0, M_TVALID=0.
    - When S_TVALID=1: compute from H and S_TDATA[255:240], write H[63:48] if E, go to SEND_HDR.
    - Beat 1 is not consumed in this state.
  - SEND_HDR
    - M_* driven from H, M_TVALID=1, S_TREADY=0.
    - On M handshake: if E, increment rewrite_count.
    - Then go to WAIT_HDR if H.TLAST, else PASS.
  - PASS
    - Combinational pass-through: M_* = S_*, M_TVALID = S_TVALID, S_TREADY = M_TREADY.
    - On a handshake with TLAST: go to WAIT_HDR.
- TSTRB and TUSER are never modified.
- Bytes outside [63:48] of beat 0 are never modified.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state = WAIT_HDR, H = 0, E = 0, rewrite_count = 0.
  - M_AXIS_TVALID = 0, M_AXIS_TDATA/TSTRB/TUSER/TLAST = 0, S_AXIS_TREADY = 1.
- Latency:
  - Beat 0 appears on M one cycle after beat 1 is first presented valid.
  - Beats 1..n add zero cycles of latency (PASS).
  - Single-beat packets appear one cycle after capture.
- Once asserted, M_TVALID stays high with stable data until M_TREADY (SEND_HDR).
- Stall rules:
  - Backpressure in SEND_HDR: H held, no input consumed.
  - Beat 1 valid dropping during WAIT_SECOND is legal; the checksum is computed on the first cycle it is valid.
- Reset mid-packet aborts H. Upstream and downstream stages are reset together, so there are no orphan beats.
- Throughput: one bubble cycle per packet (WAIT_SECOND → SEND_HDR), plus one capture cycle.

## Test plan
- Reference header 4500 0073 0000 4000 4011 xxxx c0a8 0001 c0a8 00c7, checksum field xxxx = 0000 or FFFF, 3-beat packet -> beat 0 out with [63:48] = 16'hB861, beats 1–2 bit-exact, rewrite_count = 1.
- Same packet with ethertype 0x0806, then again with version/IHL 0x46 -> output identical to input, rewrite_count unchanged.
- csum_enable = 0 with the reference header, checksum field 0x1234 -> field stays 0x1234, count unchanged, latency identical to the enabled case.
- Single-beat packet (TLAST on beat 0) -> emitted unchanged one cycle after capture, state returns to WAIT_HDR, count unchanged.
- M_TREADY low for 5 cycles in SEND_HDR, then random backpressure during PASS, back-to-back packets -> no loss or duplication, S_TREADY = 0 while holding, all checksums B861.
- Assert AXI_RESETN low in WAIT_SECOND -> M_TVALID = 0 immediately, count = 0; the next full packet is processed correctly.

Source files
------------

// File: rtl/ip_checksum_insert.sv
// ip_checksum_insert: holds beat 0 of each frame until beat 1 arrives, then
// writes the IPv4 header checksum into bytes [63:48] of beat 0 for plain
// (IHL=5) IPv4 frames. All other frames and beats pass through unchanged.
module ip_checksum_insert #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  input  logic                              csum_enable,
  output logic [31:0]                       rewrite_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic [1:0] {
    WAIT_HDR    = 2'd0,
    WAIT_SECOND = 2'd1,
    SEND_HDR    = 2'd2,
    PASS        = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  // Hold register for beat 0 plus its eligibility flag
  logic [DW-1:0]   r_h_data;
  logic [SW-1:0]   r_h_strb;
  logic [UW-1:0]   r_h_user;
  logic            r_h_last;
  logic            r_h_elig;
  logic [31:0]     r_count;

  logic            w_elig;
  logic [19:0]     w_sum;
  logic [19:0]     w_fold1;
  logic [19:0]     w_fold2;
  logic [15:0]     w_csum;

  // Frame is eligible for rewrite: enabled, IPv4 ethertype, version 4 / IHL 5
  assign w_elig = csum_enable
                  && (S_AXIS_TDATA[159:144] == 16'h0800)
                  && (S_AXIS_TDATA[143:136] == 8'h45);

  // Ones-complement header sum: words 0-4 and 6-8 from the held beat, word 9
  // from the live beat 1; the checksum word itself counts as zero
  always_comb begin
    w_sum = {4'b0, S_AXIS_TDATA[255:240]};
    for (int i = 0; i < 9; i++) begin
      if (i != 5) begin
        w_sum = w_sum + {4'b0, r_h_data[143-16*i -: 16]};
      end
    end
    w_fold1 = {4'b0, w_sum[15:0]} + {16'b0, w_sum[19:16]};
    w_fold2 = {4'b0, w_fold1[15:0]} + {16'b0, w_fold1[19:16]};
    w_csum  = ~w_fold2[15:0];
  end

  // State register
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_state <= WAIT_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_HDR: begin
        if (S_AXIS_TVALID) begin
          w_state_next = S_AXIS_TLAST ? SEND_HDR : WAIT_SECOND;
        end
      end
      WAIT_SECOND: begin
        if (S_AXIS_TVALID) begin
          w_state_next = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (M_AXIS_TREADY) begin
          w_state_next = r_h_last ? WAIT_HDR : PASS;
        end
      end
      PASS: begin
        if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
          w_state_next = WAIT_HDR;
        end
      end
      default: w_state_next = WAIT_HDR;
    endcase
  end

  // Output logic: held beat in SEND_HDR, straight wire-through in PASS
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = r_h_data;
    M_AXIS_TSTRB  = r_h_strb;
    M_AXIS_TUSER  = r_h_user;
    M_AXIS_TLAST  = r_h_last;
    case (r_state)
      WAIT_HDR: begin
        S_AXIS_TREADY = 1'b1;
      end
      SEND_HDR: begin
        M_AXIS_TVALID = 1'b1;
      end
      PASS: begin
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TSTRB  = S_AXIS_TSTRB;
        M_AXIS_TUSER  = S_AXIS_TUSER;
        M_AXIS_TLAST  = S_AXIS_TLAST;
      end
      default: ;
    endcase
  end

  // Capture beat 0, then patch its checksum field once beat 1 is visible
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_h_data <= '0;
      r_h_strb <= '0;
      r_h_user <= '0;
      r_h_last <= 1'b0;
      r_h_elig <= 1'b0;
    end else if (r_state == WAIT_HDR && S_AXIS_TVALID) begin
      r_h_data <= S_AXIS_TDATA;
      r_h_strb <= S_AXIS_TSTRB;
      r_h_user <= S_AXIS_TUSER;
      r_h_last <= S_AXIS_TLAST;
      // A single-beat frame never sees word 9, so it is never rewritten
      r_h_elig <= w_elig && !S_AXIS_TLAST;
    end else if (r_state == WAIT_SECOND && S_AXIS_TVALID && r_h_elig) begin
      r_h_data[63:48] <= w_csum;
    end
  end

  // Count rewritten headers as they leave the block
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_count <= '0;
    end else if (r_state == SEND_HDR && M_AXIS_TREADY && r_h_elig) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign rewrite_count = r_count;

endmodule

// File: tb/tb_ip_checksum_insert.sv
// Directed testbench for ip_checksum_insert: reference IPv4 header frames,
// non-eligible frames, single-beat frames, backpressure and mid-packet reset.
module tb_ip_checksum_insert;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         csum_en = 1'b1;
  logic [31:0]  rw_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats  = 0;

  beat_t in_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ip_checksum_insert dut (
    .AXI_ACLK      (clk),
    .AXI_RESETN    (rst_n),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast),
    .csum_enable   (csum_en),
    .rewrite_count (rw_count)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat 0 carrying the reference header 4500 0073 0000 4000 4011 cs c0a8 0001 c0a8
  function automatic beat_t hdr_beat(input logic [15:0] et, input logic [7:0] vi,
                                     input logic [15:0] cs, input logic last);
    beat_t b;
    b.data = {96'h00112233445566778899aabb, et, vi, 8'h00, 16'h0073, 16'h0000,
              16'h4000, 16'h4011, cs, 16'hc0a8, 16'h0001, 16'hc0a8};
    b.strb = '1;
    b.user = {112'h0000_1111_2222_3333_4444_5555_6666, et};
    b.last = last;
    return b;
  endfunction

  // Queue a frame on the input and its expected image on the output
  task automatic push_pkt(input beat_t b0, input int nbeats, input bit rw, input logic [15:0] cs);
    beat_t b;
    beat_t e;
    in_q.push_back(b0);
    e = b0;
    if (rw) e.data[63:48] = cs;
    exp_q.push_back(e);
    for (int k = 1; k < nbeats; k++) begin
      b.data = {8{32'h5A00_0000 + 32'(k * 16) + 32'(in_q.size())}};
      if (k == 1) b.data[255:240] = 16'h00c7;
      b.strb = (k == nbeats - 1) ? 32'hFFFF_0000 : 32'hFFFF_FFFF;
      b.user = b0.user ^ 128'(k);
      b.last = (k == nbeats - 1);
      in_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // Cycle engine: drive at negedge, decide ready, sample just before posedge.
  // ready_mode 0: always ready; 1: 5-cycle stall on each header, random after.
  task automatic run(input int budget, input int ready_mode, input bit gaps, output int lat);
    int    cyc = 0;
    int    first_in = -1;
    int    first_out = -1;
    int    hold_cnt = 0;
    bit    out_first = 1'b1;
    beat_t obs;
    beat_t e;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        s_tvalid = 1'b1;
        {s_tlast, s_tuser, s_tstrb, s_tdata} = in_q[0];
      end else begin
        s_tvalid = 1'b0;
      end
      #1;
      if (ready_mode == 0) begin
        m_tready = 1'b1;
      end else if (out_first && m_tvalid) begin
        m_tready = (hold_cnt >= 5);
        hold_cnt++;
      end else begin
        m_tready = ($urandom_range(0, 1) == 1);
      end
      #2;
      if (out_first && m_tvalid && !m_tready) check_eq("s_tready_hold", 512'(s_tready), 512'(0));
      if (m_tvalid && first_out < 0) first_out = cyc;
      if (s_tvalid && s_tready) begin
        if (first_in < 0) first_in = cyc;
        void'(in_q.pop_front());
      end
      if (m_tvalid && m_tready) begin
        obs = {m_tlast, m_tuser, m_tstrb, m_tdata};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("beat", 512'(obs), 512'(e));
          n_beats++;
          $display("beat %0d: csum_field=%h last=%b count=%0d", n_beats, m_tdata[63:48], m_tlast, rw_count);
        end
        if (out_first) hold_cnt = 0;
        out_first = m_tlast;
      end
      cyc++;
    end
    check_eq("run_done", 512'(in_q.size() + exp_q.size()), 512'(0));
    lat = first_out - first_in;
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    #1;
  endtask

  initial begin
    int lat;
    // Reset state
    #1;
    check_eq("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check_eq("rst_s_tready", 512'(s_tready), 512'(1));
    check_eq("rst_m_tdata", 512'(m_tdata), 512'(0));
    check_eq("rst_count", 512'(rw_count), 512'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reference header, checksum field 0000 and FFFF
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b0), 3, 1'b1, 16'hB861);
    run(200, 0, 1'b0, lat);
    check_eq("lat_ref", 512'(lat), 512'(2));
    check_eq("count_ref", 512'(rw_count), 512'(1));
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'hFFFF, 1'b0), 3, 1'b1, 16'hB861);
    run(200, 0, 1'b0, lat);
    check_eq("count_ffff", 512'(rw_count), 512'(2));

    // Non-IPv4 ethertype and IHL 6 pass unchanged
    push_pkt(hdr_beat(16'h0806, 8'h45, 16'h0000, 1'b0), 3, 1'b0, 16'h0);
    run(200, 0, 1'b0, lat);
    push_pkt(hdr_beat(16'h0800, 8'h46, 16'h0000, 1'b0), 3, 1'b0, 16'h0);
    run(200, 0, 1'b0, lat);
    check_eq("count_noelig", 512'(rw_count), 512'(2));

    // Rewrite disabled: field untouched, same latency
    csum_en = 1'b0;
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h1234, 1'b0), 3, 1'b0, 16'h0);
    run(200, 0, 1'b0, lat);
    check_eq("lat_disabled", 512'(lat), 512'(2));
    check_eq("count_disabled", 512'(rw_count), 512'(2));
    csum_en = 1'b1;

    // Single-beat frame: unchanged, one cycle after capture, back to idle
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b1), 1, 1'b0, 16'h0);
    run(200, 0, 1'b0, lat);
    check_eq("lat_single", 512'(lat), 512'(1));
    check_eq("idle_s_tready", 512'(s_tready), 512'(1));
    check_eq("idle_m_tvalid", 512'(m_tvalid), 512'(0));
    check_eq("count_single", 512'(rw_count), 512'(2));

    // Back-to-back frames with header stalls, random backpressure and gaps
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b0), 2, 1'b1, 16'hB861);
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'hFFFF, 1'b0), 3, 1'b1, 16'hB861);
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b0), 4, 1'b1, 16'hB861);
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'hABCD, 1'b0), 2, 1'b1, 16'hB861);
    run(2000, 1, 1'b1, lat);
    check_eq("count_bp", 512'(rw_count), 512'(6));

    // Reset while waiting for beat 1
    @(negedge clk);
    s_tvalid = 1'b1;
    {s_tlast, s_tuser, s_tstrb, s_tdata} = hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b0);
    m_tready = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    check_eq("wait2_s_tready", 512'(s_tready), 512'(0));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_tvalid", 512'(m_tvalid), 512'(0));
    check_eq("midrst_s_tready", 512'(s_tready), 512'(1));
    check_eq("midrst_count", 512'(rw_count), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(hdr_beat(16'h0800, 8'h45, 16'h0000, 1'b0), 3, 1'b1, 16'hB861);
    run(200, 0, 1'b0, lat);
    check_eq("count_after_rst", 512'(rw_count), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
